// File: rtl/dma_xfer_counter.sv
// ---------------------------------------------------------------------------
// dma_xfer_counter
//
// Address and transfer-count engine for one DMA channel. A load captures the
// source and destination start addresses, the transfer count and the address
// modes, then arms the channel. Each step advances both addresses by the unit
// size (2 or 4 bytes) according to their modes and counts one transfer off.
// The last step disarms the channel and raises a one-cycle terminal-count
// pulse. After terminal count, a rearm starts the same transfer again.
//
// Parameters
//   AW          address width in bits
//   CW          transfer-count width in bits (a count of 0 means 2^CW)
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous active-high reset
//   load        latch bases, count and modes, then arm the transfer
//   step        one transfer unit completed this cycle
//   rearm       repeat the transfer after terminal count
//   abort       stop the transfer, holding addresses and count
//   src_base    source start address
//   dst_base    destination start address
//   count_init  transfer count (0 means 2^CW)
//   src_mode    00 inc, 01 dec, 10 fixed, 11 inc
//   dst_mode    00 inc, 01 dec, 10 fixed, 11 inc with reload on rearm
//   word32      1: 4-byte units, 0: 2-byte units
//   src_addr    current source address
//   dst_addr    current destination address
//   remaining   transfers left (CW+1 bits so 2^CW fits)
//   active      transfer armed
//   tc          registered one-cycle terminal-count pulse
// ---------------------------------------------------------------------------
module dma_xfer_counter #(
    parameter int AW = 28,
    parameter int CW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic          rearm,
    input  logic          abort,
    input  logic [AW-1:0] src_base,
    input  logic [AW-1:0] dst_base,
    input  logic [CW-1:0] count_init,
    input  logic [1:0]    src_mode,
    input  logic [1:0]    dst_mode,
    input  logic          word32,
    output logic [AW-1:0] src_addr,
    output logic [AW-1:0] dst_addr,
    output logic [CW:0]   remaining,
    output logic          active,
    output logic          tc
);

    // The channel is either idle (disarmed) or armed and accepting steps.
    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic [1:0] MODE_DEC    = 2'b01;
    localparam logic [1:0] MODE_FIXED  = 2'b10;
    localparam logic [1:0] MODE_RELOAD = 2'b11;

    state_t        state, state_nxt;

    // Working registers
    logic [AW-1:0] src_addr_q, src_addr_nxt;
    logic [AW-1:0] dst_addr_q, dst_addr_nxt;
    logic [CW:0]   remaining_q, remaining_nxt;
    logic          tc_q, tc_nxt;

    // Settings captured at load; they define the armed transfer and any
    // later rearm, so live input changes cannot disturb it.
    logic [1:0]    src_mode_q, src_mode_nxt;
    logic [1:0]    dst_mode_q, dst_mode_nxt;
    logic          word32_q, word32_nxt;
    logic [AW-1:0] dst_base_q, dst_base_nxt;
    logic [CW:0]   count_q, count_nxt;

    // Helper values derived from the load-time inputs
    logic [AW-1:0] src_base_aligned;
    logic [AW-1:0] dst_base_aligned;
    logic [CW:0]   count_decoded;
    logic [AW-1:0] unit_size;
    logic          accept_step;
    logic          rearm_ok;

    // Clear the low address bits that cannot be set for the unit size:
    // two bits for word units, one bit for halfword units.
    function automatic logic [AW-1:0] align_addr(input logic [AW-1:0] base,
                                                 input logic          w32);
        logic [AW-1:0] mask;
        mask = w32 ? ~AW'(3) : ~AW'(1);
        return base & mask;
    endfunction

    // Advance an address by one unit according to its mode. Mode 11 counts
    // up for both channels; arithmetic wraps naturally at AW bits.
    function automatic logic [AW-1:0] advance_addr(input logic [AW-1:0] addr,
                                                   input logic [1:0]    mode,
                                                   input logic [AW-1:0] size);
        logic [AW-1:0] result;
        case (mode)
            MODE_DEC:   result = addr - size;
            MODE_FIXED: result = addr;
            default:    result = addr + size;
        endcase
        return result;
    endfunction

    // Load-time decoding: aligned bases and the count with 0 standing for
    // the full 2^CW transfers.
    always_comb begin
        src_base_aligned = align_addr(src_base, word32);
        dst_base_aligned = align_addr(dst_base, word32);
        if (count_init == '0) begin
            count_decoded = {1'b1, {CW{1'b0}}};
        end else begin
            count_decoded = {1'b0, count_init};
        end
    end

    // Step size follows the latched width, never the live input.
    assign unit_size   = word32_q ? AW'(4) : AW'(2);
    assign accept_step = (state == ARMED) && step;

    // A rearm is only meaningful once the previous transfer has run to
    // terminal count. An aborted transfer keeps a nonzero count and so
    // cannot be rearmed; the final step cycle is still ARMED, so a rearm
    // arriving with it is dropped as well.
    assign rearm_ok = (state == IDLE) && (remaining_q == '0) && rearm;

    // State register and all datapath registers. Reset clears everything,
    // which also kills an in-flight transfer without a terminal pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            src_addr_q  <= '0;
            dst_addr_q  <= '0;
            remaining_q <= '0;
            tc_q        <= 1'b0;
            src_mode_q  <= '0;
            dst_mode_q  <= '0;
            word32_q    <= 1'b0;
            dst_base_q  <= '0;
            count_q     <= '0;
        end else begin
            state       <= state_nxt;
            src_addr_q  <= src_addr_nxt;
            dst_addr_q  <= dst_addr_nxt;
            remaining_q <= remaining_nxt;
            tc_q        <= tc_nxt;
            src_mode_q  <= src_mode_nxt;
            dst_mode_q  <= dst_mode_nxt;
            word32_q    <= word32_nxt;
            dst_base_q  <= dst_base_nxt;
            count_q     <= count_nxt;
        end
    end

    // Next-state and next-datapath logic. Commands are resolved in priority
    // order abort, load, rearm, step; the first one present wins and the
    // rest are discarded for this cycle. tc defaults low so it can only be
    // a single-cycle pulse.
    always_comb begin
        state_nxt     = state;
        src_addr_nxt  = src_addr_q;
        dst_addr_nxt  = dst_addr_q;
        remaining_nxt = remaining_q;
        tc_nxt        = 1'b0;
        src_mode_nxt  = src_mode_q;
        dst_mode_nxt  = dst_mode_q;
        word32_nxt    = word32_q;
        dst_base_nxt  = dst_base_q;
        count_nxt     = count_q;

        if (abort) begin
            state_nxt = IDLE;
        end else if (load) begin
            state_nxt     = ARMED;
            src_mode_nxt  = src_mode;
            dst_mode_nxt  = dst_mode;
            word32_nxt    = word32;
            dst_base_nxt  = dst_base_aligned;
            count_nxt     = count_decoded;
            src_addr_nxt  = src_base_aligned;
            dst_addr_nxt  = dst_base_aligned;
            remaining_nxt = count_decoded;
        end else if (rearm_ok) begin
            state_nxt     = ARMED;
            remaining_nxt = count_q;
            if (dst_mode_q == MODE_RELOAD) begin
                dst_addr_nxt = dst_base_q;
            end
        end else if (accept_step) begin
            src_addr_nxt  = advance_addr(src_addr_q, src_mode_q, unit_size);
            dst_addr_nxt  = advance_addr(dst_addr_q, dst_mode_q, unit_size);
            remaining_nxt = remaining_q - 1'b1;
            if (remaining_q == (CW+1)'(1)) begin
                state_nxt = IDLE;
                tc_nxt    = 1'b1;
            end
        end
    end

    // Every output comes straight from a register.
    assign src_addr  = src_addr_q;
    assign dst_addr  = dst_addr_q;
    assign remaining = remaining_q;
    assign active    = (state == ARMED);
    assign tc        = tc_q;

endmodule

// File: tb/tb_dma_xfer_counter.sv
// ---------------------------------------------------------------------------
// tb_dma_xfer_counter
//
// Directed self-checking bench for dma_xfer_counter with the default
// parameters (AW=28, CW=14). Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_dma_xfer_counter;

    localparam int AW = 28;
    localparam int CW = 14;

    logic          clk;
    logic          rst;
    logic          load;
    logic          step;
    logic          rearm;
    logic          abort;
    logic [AW-1:0] src_base;
    logic [AW-1:0] dst_base;
    logic [CW-1:0] count_init;
    logic [1:0]    src_mode;
    logic [1:0]    dst_mode;
    logic          word32;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [CW:0]   remaining;
    logic          active;
    logic          tc;

    int checks;
    int errors;
    int early_tc;

    dma_xfer_counter #(.AW(AW), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .step       (step),
        .rearm      (rearm),
        .abort      (abort),
        .src_base   (src_base),
        .dst_base   (dst_base),
        .count_init (count_init),
        .src_mode   (src_mode),
        .dst_mode   (dst_mode),
        .word32     (word32),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .remaining  (remaining),
        .active     (active),
        .tc         (tc)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of command inputs, let one rising edge pass and
    // settle 1 ns after it before anything is sampled.
    task automatic applyStimulus(input logic ld, input logic st,
                                 input logic ra, input logic ab);
        load  = ld;
        step  = st;
        rearm = ra;
        abort = ab;
        @(posedge clk);
        #1;
        load  = 1'b0;
        step  = 1'b0;
        rearm = 1'b0;
        abort = 1'b0;
    endtask

    task automatic setLoad(input logic [AW-1:0] sb, input logic [AW-1:0] db,
                           input logic [CW-1:0] cnt, input logic [1:0] sm,
                           input logic [1:0] dm, input logic w32);
        src_base   = sb;
        dst_base   = db;
        count_init = cnt;
        src_mode   = sm;
        dst_mode   = dm;
        word32     = w32;
    endtask

    task automatic checkAll(input string tag, input logic [AW-1:0] s,
                            input logic [AW-1:0] d, input logic [CW:0] r,
                            input logic a, input logic t);
        checkOutput({tag, ".src"},    32'(src_addr),  32'(s));
        checkOutput({tag, ".dst"},    32'(dst_addr),  32'(d));
        checkOutput({tag, ".rem"},    32'(remaining), 32'(r));
        checkOutput({tag, ".active"}, 32'(active),    32'(a));
        checkOutput({tag, ".tc"},     32'(tc),        32'(t));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        load = 0; step = 0; rearm = 0; abort = 0;
        setLoad('0, '0, '0, 2'b00, 2'b00, 1'b0);

        // Reset state, checked asynchronously before any clock edge
        rst = 1'b1;
        #2;
        checkAll("reset", 28'h0, 28'h0, 15'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Step without a prior load is ignored
        applyStimulus(0, 1, 0, 0);
        checkAll("noload_step", 28'h0, 28'h0, 15'd0, 1'b0, 1'b0);

        // Basic increment transfer, word units
        setLoad(28'h100, 28'h200, 14'd3, 2'b00, 2'b00, 1'b1);
        applyStimulus(1, 0, 0, 0);
        checkAll("inc.load", 28'h100, 28'h200, 15'd3, 1'b1, 1'b0);
        applyStimulus(0, 1, 0, 0);
        checkAll("inc.s1", 28'h104, 28'h204, 15'd2, 1'b1, 1'b0);
        applyStimulus(0, 1, 0, 0);
        checkAll("inc.s2", 28'h108, 28'h208, 15'd1, 1'b1, 1'b0);
        applyStimulus(0, 1, 0, 0);
        checkAll("inc.s3", 28'h10C, 28'h20C, 15'd0, 1'b0, 1'b1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("inc.tc_drop", 32'(tc), 32'd0);
        // Rearm with dst_mode 00 keeps both addresses
        applyStimulus(0, 0, 1, 0);
        checkAll("inc.rearm", 28'h10C, 28'h20C, 15'd3, 1'b1, 1'b0);

        // Halfword decrement with wrap; inputs changed after load must not matter
        setLoad(28'h3, 28'h55, 14'd2, 2'b01, 2'b10, 1'b0);
        applyStimulus(1, 0, 0, 0);
        checkAll("dec.load", 28'h2, 28'h54, 15'd2, 1'b1, 1'b0);
        setLoad(28'h777, 28'h999, 14'd9, 2'b00, 2'b00, 1'b1);
        applyStimulus(0, 1, 0, 0);
        checkAll("dec.s1", 28'h0, 28'h54, 15'd1, 1'b1, 1'b0);
        applyStimulus(0, 1, 0, 0);
        checkAll("dec.s2", 28'hFFFFFFE, 28'h54, 15'd0, 1'b0, 1'b1);

        // dst reload on rearm; rearm alongside the final step is dropped
        setLoad(28'h1000, 28'h403, 14'd2, 2'b00, 2'b11, 1'b1);
        applyStimulus(1, 0, 0, 0);
        checkAll("rld.load", 28'h1000, 28'h400, 15'd2, 1'b1, 1'b0);
        applyStimulus(0, 1, 0, 0);
        checkAll("rld.s1", 28'h1004, 28'h404, 15'd1, 1'b1, 1'b0);
        applyStimulus(0, 1, 1, 0);
        checkAll("rld.s2", 28'h1008, 28'h408, 15'd0, 1'b0, 1'b1);
        applyStimulus(0, 0, 1, 0);
        checkAll("rld.rearm", 28'h1008, 28'h400, 15'd2, 1'b1, 1'b0);
        applyStimulus(0, 1, 0, 0);
        checkAll("rld.s3", 28'h100C, 28'h404, 15'd1, 1'b1, 1'b0);

        // Abort mid-transfer holds values; later rearm and step are ignored
        setLoad(28'h500, 28'h600, 14'd8, 2'b00, 2'b01, 1'b1);
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0);
        checkAll("abt.pre", 28'h50C, 28'h5F4, 15'd5, 1'b1, 1'b0);
        applyStimulus(0, 1, 0, 1);
        checkAll("abt.abort", 28'h50C, 28'h5F4, 15'd5, 1'b0, 1'b0);
        applyStimulus(0, 0, 1, 0);
        checkAll("abt.rearm", 28'h50C, 28'h5F4, 15'd5, 1'b0, 1'b0);
        applyStimulus(0, 1, 0, 0);
        checkAll("abt.step", 28'h50C, 28'h5F4, 15'd5, 1'b0, 1'b0);

        // abort+load: load has no effect
        setLoad(28'h800, 28'h900, 14'd4, 2'b00, 2'b00, 1'b1);
        applyStimulus(1, 0, 0, 0);
        setLoad(28'hABC0, 28'hDEF0, 14'd7, 2'b00, 2'b00, 1'b1);
        applyStimulus(1, 0, 0, 1);
        checkAll("abld", 28'h800, 28'h900, 15'd4, 1'b0, 1'b0);
        // step+load: step discarded
        setLoad(28'h2000, 28'h3000, 14'd6, 2'b00, 2'b00, 1'b1);
        applyStimulus(1, 1, 0, 0);
        checkAll("stld", 28'h2000, 28'h3000, 15'd6, 1'b1, 1'b0);
        applyStimulus(0, 1, 0, 0);
        checkAll("stld.s1", 28'h2004, 28'h3004, 15'd5, 1'b1, 1'b0);

        // Asynchronous reset mid-transfer, sampled away from any edge
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkAll("rst.async", 28'h0, 28'h0, 15'd0, 1'b0, 1'b0);
        step = 1'b1;
        @(posedge clk);
        #1;
        checkAll("rst.hold", 28'h0, 28'h0, 15'd0, 1'b0, 1'b0);
        step = 1'b0;
        rst  = 1'b0;
        applyStimulus(0, 1, 0, 0);
        checkAll("rst.noload", 28'h0, 28'h0, 15'd0, 1'b0, 1'b0);

        // count_init = 0 means 2^14 transfers
        setLoad(28'h0, 28'h0, 14'd0, 2'b00, 2'b10, 1'b1);
        applyStimulus(1, 0, 0, 0);
        checkAll("full.load", 28'h0, 28'h0, 15'd16384, 1'b1, 1'b0);
        early_tc = 0;
        for (int i = 0; i < 16383; i++) begin
            applyStimulus(0, 1, 0, 0);
            if (tc) early_tc++;
        end
        checkOutput("full.early_tc", 32'(early_tc), 32'd0);
        checkAll("full.s16383", 28'hFFFC, 28'h0, 15'd1, 1'b1, 1'b0);
        applyStimulus(0, 1, 0, 0);
        checkAll("full.last", 28'h10000, 28'h0, 15'd0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_xfer_counter.md
DMA_XFER_COUNTER -- requirements
Module: dma_xfer_counter

Interface
REQ-001 The module SHALL have parameter AW, default 28, meaning the address width in bits.
REQ-002 The module SHALL have parameter CW, default 14, meaning the transfer-count width in bits.
REQ-003 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 load  input  1  start: latch bases, count and modes; arm the transfer.
REQ-007 step  input  1  one transfer unit completed this cycle.
REQ-008 rearm  input  1  repeat request after terminal count.
REQ-009 abort  input  1  stop the transfer immediately.
REQ-010 src_base  input  AW  source start address.
REQ-011 dst_base  input  AW  destination start address.
REQ-012 count_init  input  CW  transfer count; 0 means 2^CW.
REQ-013 src_mode  input  2  00 increment, 01 decrement, 10 fixed, 11 treated as increment.
REQ-014 dst_mode  input  2  00 increment, 01 decrement, 10 fixed, 11 increment with reload on rearm.
REQ-015 word32  input  1  1: step size 4; 0: step size 2.
REQ-016 src_addr  output  AW  current source address.
REQ-017 dst_addr  output  AW  current destination address.
REQ-018 remaining  output  CW+1  transfers left.
REQ-019 active  output  1  transfer armed.
REQ-020 tc  output  1  one-cycle terminal-count pulse.

Function
REQ-021 On load, the block SHALL latch src_mode, dst_mode, word32, dst_base and count_init into internal registers; later input changes SHALL NOT affect an armed transfer.
REQ-022 On load, the block SHALL force src_addr and dst_addr to the bases with low bits cleared: bits [1:0] cleared when word32=1, bit [0] cleared when word32=0.
REQ-023 On load, the block SHALL set remaining to count_init, or to 2^CW when count_init is 0, and SHALL set active to 1 on the next edge.
REQ-024 step SHALL be ignored when active=0.
REQ-025 When step=1 and active=1, each address SHALL update by +S (increment), -S (decrement) or 0 (fixed), where S is 4 or 2 per the latched word32.
REQ-026 All address arithmetic SHALL wrap modulo 2^AW.
REQ-027 Each accepted step SHALL decrement remaining by exactly 1.
REQ-028 When a step is accepted with remaining=1, the block SHALL on the next edge set remaining to 0 and active to 0, and SHALL assert tc high for exactly that one cycle.
REQ-029 tc SHALL be registered, SHALL NOT assert at any other time, and SHALL NOT assert on abort.
REQ-030 rearm SHALL be honoured only when active=0 and remaining=0; otherwise it SHALL be ignored.
REQ-031 rearm in the same cycle as the final step SHALL be ignored.
REQ-032 A honoured rearm SHALL reload remaining from the latched count, set active to 1, and leave src_addr unchanged.
REQ-033 A honoured rearm SHALL set dst_addr to the latched aligned dst_base if the latched dst_mode is 11, and SHALL leave dst_addr unchanged otherwise.
REQ-034 abort SHALL clear active on the next edge and SHALL hold the address and remaining values.
REQ-035 Priority SHALL be abort > load > rearm > step.
REQ-036 When abort and load are asserted in the same cycle, the block SHALL end with active=0 and load SHALL have no effect.
REQ-037 When load and step are asserted in the same cycle, the load values SHALL be taken and the step discarded.
REQ-038 Latency from any input to any output SHALL be one clock edge, with no combinational input-to-output paths.

Reset
REQ-039 While rst=1, src_addr, dst_addr, remaining, active, tc and all latched mode, count and base registers SHALL be 0, independent of clk.
REQ-040 Reset asserted mid-transfer SHALL abandon the transfer with no tc pulse.
REQ-041 After rst deasserts, the block SHALL require a load before any step is accepted.

Verification
REQ-042 load src_base=0x100, dst_base=0x200, count_init=3, both modes 00, word32=1, then 3 steps -> addresses 0x104/0x204, 0x108/0x208, 0x10C/0x20C; tc high exactly one cycle after the third step; active=0; remaining=0.
REQ-043 load with word32=0, src_base=0x3, src_mode=01, count_init=2, then 2 steps -> src_addr 0x2, then 0x0, then 0x0FFFFFFE (wrap, AW=28).
REQ-044 load with count_init=0, CW=14 -> remaining=16384; tc only after 16384 steps.
REQ-045 dst_mode=11, dst_base=0x400, count_init=2, word32=1, 2 steps, then rearm -> dst_addr returns to 0x400, src_addr keeps its advanced value, remaining=2, active=1.
REQ-046 Mid-transfer abort with remaining=5 -> active=0, remaining stays 5, no tc; a subsequent rearm is ignored.
REQ-047 Simultaneous abort+load, then step+load, then rst pulsed mid-transfer -> active=0 after the first case, the second case discards the step, and all outputs read 0 during the rst pulse.
